// File: rtl/dense_feature_loader_pkg.sv
// -----------------------------------------------------------------------------
// dense_feature_loader_pkg
//
// Shared constants and types for the dense network front end. The loader and
// dense1 both import this package so they agree on the width of one float word
// and on the width of the packed frame bus.
//
// Contents:
//   FLOAT       bit width of one raw IEEE-754 single word
//   NB_INPUT    features per frame (dense1 input count)
//   DENSE*_OUT  output sizes of the downstream dense layers
//   ERR_W       width of the saturating malformed-frame counter
//   float_t / frame_t / cnt_t / err_t   matching typedefs
//   sat_inc()   saturating increment for the error counter
// -----------------------------------------------------------------------------
package dense_feature_loader_pkg;

    localparam int FLOAT      = 32;
    localparam int NB_INPUT   = 42;
    localparam int DENSE1_OUT = 24;
    localparam int DENSE2_OUT = 96;
    localparam int DENSE3_OUT = 22;
    localparam int DENSE4_OUT = 1;
    localparam int ERR_W      = 8;

    localparam int FRAME_W = NB_INPUT * FLOAT;
    localparam int CNT_W   = $clog2(NB_INPUT);

    typedef logic [FLOAT-1:0]   float_t;
    typedef logic [FRAME_W-1:0] frame_t;
    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [ERR_W-1:0]   err_t;

    // Counter sticks at all-ones instead of wrapping back to zero.
    function automatic err_t sat_inc(input err_t v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dense_feature_loader_if.sv
// -----------------------------------------------------------------------------
// dense_feature_loader_if
//
// Bundles the two streams of the loader:
//   input word stream  : in_data, in_valid, in_last (producer -> loader)
//                        in_ready                   (loader -> producer)
//   output frame stream: frame_out, frame_valid     (loader -> consumer)
//                        frame_ack                  (consumer -> loader)
//
// Handshake rules (both streams): a transfer happens in a cycle where the
// sender's valid and the receiver's ready/ack are both 1 at the rising clock
// edge. While valid is high and the transfer has not happened, the sender
// holds its payload (in_data/in_last, frame_out) unchanged. ready/ack
// asserted without valid has no effect.
//
// Modports:
//   master - producer/consumer side (drives the word stream, acks frames)
//   slave  - the loader itself
// -----------------------------------------------------------------------------
interface dense_feature_loader_if;
    import dense_feature_loader_pkg::*;

    float_t in_data;
    logic   in_valid;
    logic   in_last;
    logic   in_ready;
    frame_t frame_out;
    logic   frame_valid;
    logic   frame_ack;

    modport master (
        output in_data,
        output in_valid,
        output in_last,
        output frame_ack,
        input  in_ready,
        input  frame_out,
        input  frame_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  in_last,
        input  frame_ack,
        output in_ready,
        output frame_out,
        output frame_valid
    );

endinterface

// File: rtl/dense_feature_loader_feature_bank.sv
// -----------------------------------------------------------------------------
// dense_feature_loader_feature_bank
//
// NB_INPUT x FLOAT register file holding one frame. One synchronous write
// port, and the whole contents presented as a packed read bus with word k at
// [k*FLOAT +: FLOAT].
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset, clears every word to 0
//   we_i    write enable
//   addr_i  word index to write (0..NB_INPUT-1)
//   data_i  word to write
//   rd_o    packed contents of the bank
// -----------------------------------------------------------------------------
module dense_feature_loader_feature_bank
    import dense_feature_loader_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   we_i,
    input  cnt_t   addr_i,
    input  float_t data_i,
    output frame_t rd_o
);

    float_t mem_q [NB_INPUT];

    // Per-word address compare keeps every index in range even though the
    // address bus can encode values above NB_INPUT-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NB_INPUT; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NB_INPUT; i++) begin
                if (we_i && (addr_i == CNT_W'(i))) begin
                    mem_q[i] <= data_i;
                end
            end
        end
    end

    always_comb begin
        rd_o = '0;
        for (int i = 0; i < NB_INPUT; i++) begin
            rd_o[i*FLOAT +: FLOAT] = mem_q[i];
        end
    end

endmodule

// File: rtl/dense_feature_loader.sv
// -----------------------------------------------------------------------------
// dense_feature_loader
//
// Staging stage in front of dense1. Collects NB_INPUT float words, one per
// cycle, and presents them as one packed frame. Two banks form a ping-pong
// buffer: a new frame fills the write bank while the consumer holds the
// frame in the read bank. Frames whose in_last does not line up with word
// NB_INPUT-1 are dropped and counted.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   bus      stream interface (slave side): in_data/in_valid/in_last/in_ready
//            word stream in, frame_out/frame_valid/frame_ack frame stream out
//   err_len  one-cycle pulse, the cycle after a malformed frame is dropped
//   err_cnt  saturating count of dropped frames
// -----------------------------------------------------------------------------
module dense_feature_loader
    import dense_feature_loader_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    dense_feature_loader_if.slave   bus,
    output logic                    err_len,
    output err_t                    err_cnt
);

    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;
    logic [1:0] full_q,    full_d;
    cnt_t       cnt_q,     cnt_d;
    logic       err_len_q, err_len_d;
    err_t       err_cnt_q, err_cnt_d;

    logic       accept;
    logic       at_end;
    logic       complete;
    logic       malformed;
    logic       ack;
    logic [1:0] bank_we;
    frame_t     bank_rd [2];

    // in_ready depends only on registered state, so there is no
    // combinational path from in_valid back to in_ready.
    assign bus.in_ready = !full_q[wr_bank_q];

    assign accept    = bus.in_valid && bus.in_ready;
    assign at_end    = (cnt_q == CNT_W'(NB_INPUT - 1));
    assign complete  = accept && at_end && bus.in_last;
    // Either in_last arrives early, or the last slot is filled without it.
    assign malformed = accept && (at_end != bus.in_last);
    assign ack       = bus.frame_ack && full_q[rd_bank_q];

    always_comb begin
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;
        cnt_d     = cnt_q;
        err_len_d = 1'b0;
        err_cnt_d = err_cnt_q;

        if (accept) begin
            if (complete) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                cnt_d             = '0;
            end else if (malformed) begin
                // Bank stays not-full; its partial contents are simply
                // overwritten by the next frame.
                cnt_d     = '0;
                err_len_d = 1'b1;
                err_cnt_d = sat_inc(err_cnt_q);
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Completion needs the write bank empty and ack needs the read bank
        // full, so when both fire they always touch different banks and the
        // two updates to full_d never collide.
        if (ack) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q    <= 2'b00;
            cnt_q     <= '0;
            err_len_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
            cnt_q     <= cnt_d;
            err_len_q <= err_len_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // A bank is only written while it is not full, and the read bank is
    // full whenever frame_valid is high, so a presented frame never changes
    // under the consumer.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign bank_we[b] = accept && (wr_bank_q == 1'(b));

        dense_feature_loader_feature_bank u_bank (
            .clk    (clk),
            .rst    (rst),
            .we_i   (bank_we[b]),
            .addr_i (cnt_q),
            .data_i (bus.in_data),
            .rd_o   (bank_rd[b])
        );
    end

    assign bus.frame_out   = rd_bank_q ? bank_rd[1] : bank_rd[0];
    assign bus.frame_valid = full_q[rd_bank_q];
    assign err_len         = err_len_q;
    assign err_cnt         = err_cnt_q;

endmodule

// File: tb/tb_dense_feature_loader.sv
// -----------------------------------------------------------------------------
// tb_dense_feature_loader
//
// Self-checking bench for dense_feature_loader. Inputs are driven 1 time unit
// after the rising edge, outputs are sampled on the falling edge. Every frame
// expected to be delivered is pushed onto exp_q when it is driven; the
// monitor pops and compares whenever the consumer acks a valid frame.
// -----------------------------------------------------------------------------
module tb_dense_feature_loader;
    import dense_feature_loader_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic err_len;
    err_t err_cnt;

    always #5 clk = ~clk;

    dense_feature_loader_if intf ();

    dense_feature_loader dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (intf),
        .err_len (err_len),
        .err_cnt (err_cnt)
    );

    // ---------------- bookkeeping ----------------
    int     checks      = 0;
    int     errors      = 0;
    int     err_pulses  = 0;
    int     stall_cnt   = 0;
    bit     stall_watch = 1'b0;
    frame_t exp_q [$];

    typedef struct {
        logic [31:0] base;
        int          nwords;
        int          last_idx;   // -1: no word carries in_last
        int          exp_errs;   // malformed frames this record produces
        bit          exp_good;   // record is delivered as a frame
    } vec_t;

    vec_t vecs [7];

    function automatic frame_t make_frame(input logic [31:0] base);
        frame_t f;
        f = '0;
        for (int k = 0; k < NB_INPUT; k++) begin
            f[k*FLOAT +: FLOAT] = base + 32'(k);
        end
        return f;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_frame(input string name, input frame_t act, input frame_t exp);
        checks++;
        if (act !== exp) begin
            int idx;
            idx = 0;
            for (int k = NB_INPUT - 1; k >= 0; k--) begin
                if (act[k*FLOAT +: FLOAT] !== exp[k*FLOAT +: FLOAT]) idx = k;
            end
            errors++;
            $display("FAIL %s: word %0d got %h expected %h", name, idx,
                     act[idx*FLOAT +: FLOAT], exp[idx*FLOAT +: FLOAT]);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (err_len === 1'b1) err_pulses++;
            if (stall_watch && intf.in_valid && !intf.in_ready) stall_cnt++;
            if (intf.frame_valid && intf.frame_ack) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_extra: frame word0=%h delivered, expected none",
                             intf.frame_out[31:0]);
                end else begin
                    check_frame("sb_frame", intf.frame_out, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- drivers ----------------
    // Entered and left 1 unit after a rising edge; returns once accepted.
    task automatic send_word(input float_t d, input bit last);
        bit done;
        done          = 1'b0;
        intf.in_data  = d;
        intf.in_valid = 1'b1;
        intf.in_last  = last;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (intf.in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: word %h in_ready got 0 expected 1", d);
        end
    endtask

    task automatic send_frame(input logic [31:0] base, input int nwords,
                              input int last_idx, input bit ack_on_last);
        for (int k = 0; k < nwords; k++) begin
            if (ack_on_last && k == nwords - 1) intf.frame_ack = 1'b1;
            send_word(base + 32'(k), k == last_idx);
        end
        intf.in_valid = 1'b0;
        intf.in_last  = 1'b0;
        if (ack_on_last) intf.frame_ack = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check(name, exp_q.size(), 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int          errs_exp;
        int          pulse_base;
        logic [31:0] base;

        intf.in_data   = '0;
        intf.in_valid  = 1'b0;
        intf.in_last   = 1'b0;
        intf.frame_ack = 1'b0;
        rst            = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", intf.in_ready, 1);
        check("rst_frame_valid", intf.frame_valid, 0);
        check("rst_err_len", err_len, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_frame_out_w0", intf.frame_out[63:0], 0);
        @(posedge clk);
        #1;

        // Back-to-back frames, ack held high, in_ready must never drop
        intf.frame_ack = 1'b1;
        stall_watch    = 1'b1;
        for (int f = 0; f < 3; f++) begin
            base = 32'h3F800000 + 32'(f << 8);
            exp_q.push_back(make_frame(base));
            send_frame(base, NB_INPUT, NB_INPUT - 1, 1'b0);
        end
        stall_watch = 1'b0;
        wait_drain("b2b_drain");
        check("b2b_no_stall", stall_cnt, 0);

        // Table-driven frame shapes, ack held high
        vecs[0] = '{32'h3F800000, 42, 41, 0, 1'b1};  // well-formed
        vecs[1] = '{32'h41000000, 11, 10, 1, 1'b0};  // short: in_last on word 10
        vecs[2] = '{32'h41100000, 42, 41, 0, 1'b1};  // recovers after short
        vecs[3] = '{32'h41200000, 43, 42, 2, 1'b0};  // long, then lone in_last word
        vecs[4] = '{32'h41300000, 42, 41, 0, 1'b1};  // next word starts at cnt=0
        vecs[5] = '{32'h41400000,  1,  0, 1, 1'b0};  // single-word frame
        vecs[6] = '{32'h41500000, 42, 41, 0, 1'b1};
        errs_exp   = 0;
        pulse_base = err_pulses;
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].exp_good) exp_q.push_back(make_frame(vecs[i].base));
            send_frame(vecs[i].base, vecs[i].nwords, vecs[i].last_idx, 1'b0);
            @(negedge clk);
            check(vecs[i].exp_good ? "tbl_latency_valid" : "tbl_bad_no_valid",
                  intf.frame_valid, vecs[i].exp_good ? 1 : 0);
            repeat (3) @(posedge clk);
            #1;
            errs_exp += vecs[i].exp_errs;
            check("tbl_err_cnt", err_cnt, errs_exp);
            check("tbl_err_pulses", err_pulses - pulse_base, errs_exp);
            check("tbl_delivered", exp_q.size(), 0);
        end
        intf.frame_ack = 1'b0;

        // Back-pressure: no ack, two frames fill both banks
        exp_q.push_back(make_frame(32'h40000000));
        send_frame(32'h40000000, NB_INPUT, NB_INPUT - 1, 1'b0);
        exp_q.push_back(make_frame(32'h40100000));
        send_frame(32'h40100000, NB_INPUT, NB_INPUT - 1, 1'b0);
        @(negedge clk);
        check("bp_ready_low", intf.in_ready, 0);
        check("bp_valid", intf.frame_valid, 1);
        @(posedge clk);
        #1;
        intf.in_data  = 32'h40200000;   // third frame waits on word 0
        intf.in_valid = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check_frame("bp_stable", intf.frame_out, make_frame(32'h40000000));
        check("bp_ready_held", intf.in_ready, 0);
        @(posedge clk);
        #1;
        intf.frame_ack = 1'b1;
        @(posedge clk);
        #1;
        intf.frame_ack = 1'b0;
        intf.in_valid  = 1'b0;
        @(negedge clk);
        check("bp_next_valid", intf.frame_valid, 1);
        check_frame("bp_next_frame", intf.frame_out, make_frame(32'h40100000));
        check("bp_ready_back", intf.in_ready, 1);
        @(posedge clk);
        #1;
        exp_q.push_back(make_frame(32'h40200000));
        send_frame(32'h40200000, NB_INPUT, NB_INPUT - 1, 1'b0);
        intf.frame_ack = 1'b1;
        wait_drain("bp_drain");
        intf.frame_ack = 1'b0;
        @(posedge clk);
        #1;

        // Completion of B in the same cycle as the ack of A
        exp_q.push_back(make_frame(32'h42000000));
        send_frame(32'h42000000, NB_INPUT, NB_INPUT - 1, 1'b0);
        exp_q.push_back(make_frame(32'h42100000));
        send_frame(32'h42100000, NB_INPUT, NB_INPUT - 1, 1'b1);
        @(negedge clk);
        check("sim_valid", intf.frame_valid, 1);
        check_frame("sim_frame_b", intf.frame_out, make_frame(32'h42100000));
        check("sim_queue_one", exp_q.size(), 1);
        @(posedge clk);
        #1;
        intf.frame_ack = 1'b1;
        wait_drain("sim_drain");
        intf.frame_ack = 1'b0;
        @(posedge clk);
        #1;
        check("sim_empty_after", intf.frame_valid, 0);

        // Asynchronous reset mid-frame with one frame held
        exp_q.push_back(make_frame(32'h43000000));
        send_frame(32'h43000000, NB_INPUT, NB_INPUT - 1, 1'b0);
        send_frame(32'h43100000, 20, -1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("arst_in_ready", intf.in_ready, 1);
        check("arst_frame_valid", intf.frame_valid, 0);
        check("arst_err_len", err_len, 0);
        check("arst_err_cnt", err_cnt, 0);
        check_frame("arst_frame_out", intf.frame_out, '0);
        exp_q.delete();
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        intf.frame_ack = 1'b1;
        exp_q.push_back(make_frame(32'h44000000));
        send_frame(32'h44000000, NB_INPUT, NB_INPUT - 1, 1'b0);
        wait_drain("arst_fresh_frame");
        check("arst_err_cnt_after", err_cnt, 0);

        // 256 malformed single-word frames saturate the counter
        pulse_base = err_pulses;
        for (int i = 0; i < 256; i++) begin
            send_word(32'h45000000 + 32'(i), 1'b1);
        end
        intf.in_valid = 1'b0;
        intf.in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("sat_err_cnt", err_cnt, 255);
        check("sat_err_pulses", err_pulses - pulse_base, 256);
        check("sat_no_valid", intf.frame_valid, 0);
        check("sat_no_extra_frames", exp_q.size(), 0);
        intf.frame_ack = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
